// File: rtl/uart_rx_os_if.sv
// Receive-FIFO read port of uart_rx_os. The CPU side (master) pops entries and
// clears overrun; the receiver (slave) presents the head entry and FIFO status.
interface uart_rx_os_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          rd_en;
  logic          ovr_clr;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          rd_ferr;
  logic          rd_brk;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          overrun;

  modport master (
    output rd_en, ovr_clr,
    input  rd_data, rd_perr, rd_ferr, rd_brk, empty, full, level, overrun
  );

  modport slave (
    input  rd_en, ovr_clr,
    output rd_data, rd_perr, rd_ferr, rd_brk, empty, full, level, overrun
  );
endinterface

// File: rtl/uart_rx_os.sv
// 16x-oversampled UART receiver with majority voting, run-time frame format and
// a tagged FWFT receive FIFO. Define UART_RX_TIMEOUT_EN to build the character timeout.
module uart_rx_os #(
  parameter int DEPTH        = 16,
  parameter int DIV_W        = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic             clk,
  input  logic             rx_rstn,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_len,
  input  logic             parity_en,
  input  logic [1:0]       parity_sel,
  input  logic             stop2,
  uart_rx_os_if.slave      bus,
  output logic             busy,
  output logic             timeout
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_os: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_BITS < 1) begin : g_timeout_chk
    $error("uart_rx_os: TIMEOUT_BITS must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  typedef struct packed {
    logic       brk;
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } entry_t;

  // Two-flop synchroniser plus one edge-detect stage; all idle high.
  logic rx_s1, rx_s2, rx_d;
  always_ff @(posedge clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  state_t state;
  logic   start_det;
  assign start_det = (state == IDLE) && rx_d && !rx_s2;

  logic [DIV_W-1:0] div_eff, div_cnt;
  logic             tick;
  assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign tick    = (div_cnt >= div_eff - DIV_W'(1));

  always_ff @(posedge clk or negedge rx_rstn) begin
    if (!rx_rstn)               div_cnt <= '0;
    else if (start_det || tick) div_cnt <= '0;
    else                        div_cnt <= div_cnt + DIV_W'(1);
  end

  logic [3:0] tick_idx;
  logic       samp7, samp8;
  logic       bit_val, mid, bit_end;
  assign bit_val = (samp7 & samp8) | (samp7 & rx_s2) | (samp8 & rx_s2);
  assign mid     = tick && (tick_idx == 4'd9);
  assign bit_end = tick && (tick_idx == 4'd15);

  logic [1:0] len_l, par_sel_l;
  logic       par_en_l, stop2_l;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       par_bit, brk_acc, ferr_acc;

  logic   last_stop, push, par_x, perr_raw;
  entry_t push_entry;

  // NOTE: every variable written here gets a default first so no latch can form.
  always_comb begin
    last_stop       = (state == STOP2) || (state == STOP1 && !stop2_l);
    push            = mid && last_stop;
    par_x           = ^{shreg, par_bit};
    perr_raw        = 1'b0;
    case (par_sel_l)
      2'b00:   perr_raw = (par_x != 1'b1);
      2'b01:   perr_raw = (par_x != 1'b0);
      2'b10:   perr_raw = (par_bit != 1'b1);
      default: perr_raw = (par_bit != 1'b0);
    endcase
    push_entry.data = shreg;
    push_entry.perr = par_en_l && perr_raw;
    push_entry.ferr = ferr_acc | ~bit_val;
    push_entry.brk  = (state == STOP1) ? (brk_acc & ~bit_val) : brk_acc;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      tick_idx  <= '0;
      samp7     <= 1'b1;
      samp8     <= 1'b1;
      len_l     <= '0;
      par_sel_l <= '0;
      par_en_l  <= 1'b0;
      stop2_l   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      brk_acc   <= 1'b0;
      ferr_acc  <= 1'b0;
    end else begin
      if (tick) begin
        tick_idx <= tick_idx + 4'd1;
        if (tick_idx == 4'd7) samp7 <= rx_s2;
        if (tick_idx == 4'd8) samp8 <= rx_s2;
      end
      unique case (state)
        IDLE: if (start_det) begin
          state     <= START;
          busy      <= 1'b1;
          tick_idx  <= '0;
          len_l     <= data_len;
          par_en_l  <= parity_en;
          par_sel_l <= parity_sel;
          stop2_l   <= stop2;
          shreg     <= '0;
          bit_cnt   <= '0;
          par_bit   <= 1'b0;
          brk_acc   <= 1'b1;
          ferr_acc  <= 1'b0;
        end
        START: begin
          if (mid && bit_val) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (mid) begin
            shreg[bit_cnt] <= bit_val;
            brk_acc        <= brk_acc & ~bit_val;
          end
          // Last data bit index is 4 + data_len.
          if (bit_end) begin
            if (bit_cnt == {1'b1, len_l}) state <= par_en_l ? PARITY : STOP1;
            else                          bit_cnt <= bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          if (mid) begin
            par_bit <= bit_val;
            brk_acc <= brk_acc & ~bit_val;
          end else if (bit_end) begin
            state <= STOP1;
          end
        end
        STOP1: begin
          if (mid) begin
            if (stop2_l) begin
              ferr_acc <= ~bit_val;
              brk_acc  <= brk_acc & ~bit_val;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (bit_end) begin
            state <= STOP2;
          end
        end
        STOP2: if (mid) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr, rd_ptr, fill;
  logic        empty_i, full_i, pop, wr;

  assign fill    = wr_ptr - rd_ptr;
  assign empty_i = (fill == '0);
  assign full_i  = (fill == (AW+1)'(DEPTH));
  assign pop     = bus.rd_en && !empty_i;
  assign wr      = push && (!full_i || pop);

  // NOTE: storage is not reset; an empty FIFO masks the head to zero instead.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or negedge rx_rstn) begin
    if (!rx_rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bus.overrun <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      // A dropped character outranks a simultaneous clear.
      if (push && !wr)      bus.overrun <= 1'b1;
      else if (bus.ovr_clr) bus.overrun <= 1'b0;
    end
  end

  assign head        = empty_i ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.rd_data = head.data;
  assign bus.rd_perr = head.perr;
  assign bus.rd_ferr = head.ferr;
  assign bus.rd_brk  = head.brk;
  assign bus.empty   = empty_i;
  assign bus.full    = full_i;
  assign bus.level   = fill;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = 16 * TIMEOUT_BITS;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] to_cnt;
  always_ff @(posedge clk or negedge rx_rstn) begin
    if (!rx_rstn)                 to_cnt <= '0;
    else if (push || pop || busy) to_cnt <= '0;
    else if (tick && !empty_i && to_cnt < TO_W'(TO_LIMIT))
      to_cnt <= to_cnt + TO_W'(1);
  end
  assign timeout = (to_cnt >= TO_W'(TO_LIMIT));
`else
  assign timeout = 1'b0;
`endif

endmodule
